// File: rtl/eth_mon_pkg.sv
// Shared types and defaults for the receive-side activity monitor.
package eth_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIVE,
    TIMEOUT
  } mon_state_e;

  localparam int TIMEOUT_S_DEF = 3;
  localparam int CNT_W_DEF     = 32;
  localparam int TIMEOUT_S_MAX = 15;

endpackage

// File: rtl/sat_acc.sv
// Saturating counter; `next` is the value including this cycle's increment,
// so a window snapshot taken on the clear cycle still sees the last count.
module sat_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] next
);

  logic [W-1:0] acc_q;

  assign next = (inc && (acc_q != '1)) ? acc_q + W'(1) : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= next;
    end
  end

endmodule

// File: rtl/rx_activity_monitor.sv
// Per-second GMII receive statistics plus a frame-free link watchdog.
module rx_activity_monitor
  import eth_mon_pkg::*;
#(
  parameter int TIMEOUT_S = TIMEOUT_S_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             rx_clk,
  input  logic             rst_n,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic             timer_pulse,
  output logic             link_alive,
  output logic             timeout_pulse,
  output logic             stats_valid,
  output logic [CNT_W-1:0] frame_cnt_sec,
  output logic [CNT_W-1:0] byte_cnt_sec,
  output logic [CNT_W-1:0] err_cnt_sec
);

  if (TIMEOUT_S < 1 || TIMEOUT_S > TIMEOUT_S_MAX) begin : g_bad_timeout
    $error("rx_activity_monitor: TIMEOUT_S out of range 1..15");
  end

  logic             rx_dv_q;
  logic             err_seen_q;
  logic             err_seen_d;
  logic             sof;
  logic             err_inc;
  logic [CNT_W-1:0] frame_next;
  logic [CNT_W-1:0] byte_next;
  logic [CNT_W-1:0] err_next;
  mon_state_e       state_q;
  logic [3:0]       idle_secs_q;
  logic             link_alive_q;
  logic             timeout_pulse_q;
  logic             stats_valid_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [CNT_W-1:0] byte_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;

  assign sof = rx_dv & ~rx_dv_q;

  // A frame counts as errored once; the flag restarts at each frame start.
  assign err_inc    = rx_dv & rx_er & (sof | ~err_seen_q);
  assign err_seen_d = sof ? rx_er : (err_seen_q | (rx_dv & rx_er));

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      rx_dv_q    <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      rx_dv_q    <= rx_dv;
      err_seen_q <= err_seen_d;
    end
  end

  sat_acc #(.W(CNT_W)) u_frame_acc (
    .clk(rx_clk), .rst_n(rst_n), .inc(sof), .clr(timer_pulse), .next(frame_next)
  );

  sat_acc #(.W(CNT_W)) u_byte_acc (
    .clk(rx_clk), .rst_n(rst_n), .inc(rx_dv), .clr(timer_pulse), .next(byte_next)
  );

  sat_acc #(.W(CNT_W)) u_err_acc (
    .clk(rx_clk), .rst_n(rst_n), .inc(err_inc), .clr(timer_pulse), .next(err_next)
  );

  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      stats_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      byte_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      stats_valid_q <= timer_pulse;
      if (timer_pulse) begin
        frame_cnt_q <= frame_next;
        byte_cnt_q  <= byte_next;
        err_cnt_q   <= err_next;
      end
    end
  end

  // A frame start always wins over a coincident second boundary.
  always_ff @(posedge rx_clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idle_secs_q     <= 4'd0;
      link_alive_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else if (sof) begin
      state_q         <= ALIVE;
      idle_secs_q     <= 4'd0;
      link_alive_q    <= 1'b1;
      timeout_pulse_q <= 1'b0;
    end else if (timer_pulse && (state_q == ALIVE)) begin
      idle_secs_q <= idle_secs_q + 4'd1;
      if (idle_secs_q == 4'(TIMEOUT_S - 1)) begin
        state_q         <= TIMEOUT;
        link_alive_q    <= 1'b0;
        timeout_pulse_q <= 1'b1;
      end else begin
        link_alive_q    <= 1'b1;
        timeout_pulse_q <= 1'b0;
      end
    end else begin
      link_alive_q    <= (state_q == ALIVE);
      timeout_pulse_q <= 1'b0;
    end
  end

  assign link_alive    = link_alive_q;
  assign timeout_pulse = timeout_pulse_q;
  assign stats_valid   = stats_valid_q;
  assign frame_cnt_sec = frame_cnt_q;
  assign byte_cnt_sec  = byte_cnt_q;
  assign err_cnt_sec   = err_cnt_q;

endmodule
